// File: rtl/fetch_pkg.sv
// Shared fetch definitions: FSM state encoding, controller opcode set,
// program-RAM read latency and a saturating 16-bit add used by the statistics.
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DONE  = 2'd2
   } fetch_state_t;

   typedef enum logic [3:0] {
      OP_NOP    = 4'd0,
      OP_LOAD   = 4'd1,
      OP_STORE  = 4'd2,
      OP_ADD    = 4'd3,
      OP_SUB    = 4'd4,
      OP_JUMP   = 4'd5,
      OP_BRANCH = 4'd6,
      OP_END    = 4'd15
   } opcode_t;

   localparam int BRAM_READ_LATENCY = 2;

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] w_sum;
      w_sum = {1'b0, a} + {1'b0, b};
      return w_sum[16] ? 16'hFFFF : w_sum[15:0];
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with clear, occupancy count and a zeroed head when empty.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int WIDTH = 41,
   parameter int DEPTH = 4
)(
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     clear_in,
   input  logic                     push_in,
   input  logic [WIDTH-1:0]         push_data_in,
   input  logic                     pop_in,
   output logic [WIDTH-1:0]         pop_data_out,
   output logic                     full_out,
   output logic                     empty_out,
   output logic [$clog2(DEPTH):0]   count_out
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_push;
   logic             w_pop;

   assign full_out  = (r_count == (PTR_W+1)'(DEPTH));
   assign empty_out = (r_count == '0);
   assign count_out = r_count;
   assign w_push    = push_in & ~full_out & ~clear_in;
   assign w_pop     = pop_in & ~empty_out & ~clear_in;
   assign pop_data_out = empty_out ? '0 : r_mem[r_rd_ptr];

   // Pointers and occupancy; clear wins over any push or pop in the same cycle.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (clear_in) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= push_data_in;
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction prefetcher: credit-limited BRAM reads feeding a FIFO toward the controller.
// Optional FETCH_STATS_EN adds saturating read / flush counters.
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter int INSTRUCTION_WIDTH = 32,
   parameter int INSTRUCTION_COUNT = 512,
   parameter int FIFO_DEPTH        = 4,
   localparam int ADDR_W           = $clog2(INSTRUCTION_COUNT)
)(
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         start_in,
   input  logic                         halt_in,
   input  logic                         redirect_in,
   input  logic [ADDR_W-1:0]            redirect_addr_in,
   output logic [ADDR_W-1:0]            bram_addr_out,
   output logic                         bram_en_out,
   input  logic [INSTRUCTION_WIDTH-1:0] bram_data_in,
   output logic [INSTRUCTION_WIDTH-1:0] instr_out,
   output logic [ADDR_W-1:0]            instr_pc_out,
   output logic                         instr_valid_out,
   input  logic                         instr_ready_in,
   output logic                         busy_out
`ifdef FETCH_STATS_EN
   ,
   output logic [15:0]                  fetch_count_out,
   output logic [15:0]                  flush_count_out
`endif
);

   localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int LAT     = BRAM_READ_LATENCY;
   localparam int ENTRY_W = ADDR_W + INSTRUCTION_WIDTH;
   localparam logic [ADDR_W:0] LP_COUNT = (ADDR_W+1)'(INSTRUCTION_COUNT);
   localparam logic [ADDR_W:0] LP_LAST  = (ADDR_W+1)'(INSTRUCTION_COUNT - 1);
   localparam logic [CNT_W:0]  LP_DEPTH = (CNT_W+1)'(FIFO_DEPTH);

   fetch_state_t      r_state;
   logic [ADDR_W:0]   r_pc;
   logic [LAT-1:0]    r_pipe_valid;
   logic [ADDR_W-1:0] r_pipe_pc [LAT];

   logic               w_busy;
   logic               w_oob;
   logic               w_halt;
   logic               w_redirect;
   logic               w_flush;
   logic               w_start;
   logic               w_issue;
   logic               w_push;
   logic               w_pop;
   logic               w_fifo_full;
   logic               w_fifo_empty;
   logic [CNT_W-1:0]   w_fifo_count;
   logic [CNT_W:0]     w_occupancy;
   logic [ENTRY_W-1:0] w_head;

   assign w_busy      = (r_state != ST_IDLE);
   assign w_oob       = ({1'b0, redirect_addr_in} >= LP_COUNT);
   assign w_halt      = halt_in | (redirect_in & w_oob);
   assign w_redirect  = redirect_in & ~w_oob & ~halt_in & w_busy;
   assign w_flush     = w_halt | w_redirect;
   assign w_start     = start_in & ~w_busy & ~w_flush;
   // Reads still in flight reserve a FIFO slot, so a push can never find it full.
   assign w_occupancy = (CNT_W+1)'(w_fifo_count) + (CNT_W+1)'($countones(r_pipe_valid));
   assign w_issue     = (r_state == ST_FETCH) && (w_occupancy < LP_DEPTH);
   assign w_push      = r_pipe_valid[LAT-1] & ~w_flush & ~w_fifo_full;
   assign w_pop       = ~w_fifo_empty & instr_ready_in;

   // Fetch FSM and program counter; halt beats redirect beats start.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state <= ST_IDLE;
         r_pc    <= '0;
      end else if (w_halt) begin
         r_state <= ST_IDLE;
         r_pc    <= '0;
      end else if (w_redirect) begin
         r_state <= ST_FETCH;
         r_pc    <= {1'b0, redirect_addr_in};
      end else if (w_start) begin
         r_state <= ST_FETCH;
         r_pc    <= '0;
      end else if (w_issue) begin
         r_pc <= r_pc + (ADDR_W+1)'(1);
         if (r_pc == LP_LAST) begin
            r_state <= ST_DONE;
         end
      end
   end

   // One tracker stage per cycle of RAM latency; a flush kills every stage.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_pipe_valid <= '0;
         for (int i = 0; i < LAT; i++) begin
            r_pipe_pc[i] <= '0;
         end
      end else begin
         r_pipe_valid <= {r_pipe_valid[LAT-2:0], w_issue} & {LAT{~w_flush}};
         r_pipe_pc[0] <= r_pc[ADDR_W-1:0];
         for (int i = 1; i < LAT; i++) begin
            r_pipe_pc[i] <= r_pipe_pc[i-1];
         end
      end
   end

   fetch_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .clear_in     (w_flush),
      .push_in      (w_push),
      .push_data_in ({r_pipe_pc[LAT-1], bram_data_in}),
      .pop_in       (w_pop),
      .pop_data_out (w_head),
      .full_out     (w_fifo_full),
      .empty_out    (w_fifo_empty),
      .count_out    (w_fifo_count)
   );

   assign bram_en_out     = w_issue;
   assign bram_addr_out   = r_pc[ADDR_W-1:0];
   assign instr_valid_out = ~w_fifo_empty;
   assign instr_pc_out    = w_head[ENTRY_W-1 -: ADDR_W];
   assign instr_out       = w_head[INSTRUCTION_WIDTH-1:0];
   assign busy_out        = w_busy;

`ifdef FETCH_STATS_EN
   logic [15:0] r_fetch_count;
   logic [15:0] r_flush_count;
   logic [15:0] w_discard;

   // A head accepted in the flush cycle is consumed, not discarded.
   assign w_discard = 16'(w_fifo_count) - 16'(w_pop) + 16'($countones(r_pipe_valid));

   // Saturating statistics, cleared by an accepted start.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_fetch_count <= 16'd0;
         r_flush_count <= 16'd0;
      end else if (w_start) begin
         r_fetch_count <= 16'd0;
         r_flush_count <= 16'd0;
      end else begin
         if (w_issue) begin
            r_fetch_count <= sat_add16(r_fetch_count, 16'd1);
         end
         if (w_flush) begin
            r_flush_count <= sat_add16(r_flush_count, w_discard);
         end
      end
   end

   assign fetch_count_out = r_fetch_count;
   assign flush_count_out = r_flush_count;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed phases push expected heads,
// a negedge monitor pops and compares on every accepted head.
module tb_instruction_fetch;

   localparam int IW = 32;
   localparam int IC = 8;
   localparam int FD = 4;
   localparam int AW = 3;

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic          start_in;
   logic          halt_in;
   logic          redirect_in;
   logic [AW-1:0] redirect_addr_in;
   logic [AW-1:0] bram_addr_out;
   logic          bram_en_out;
   logic [IW-1:0] bram_data_in;
   logic [IW-1:0] instr_out;
   logic [AW-1:0] instr_pc_out;
   logic          instr_valid_out;
   logic          instr_ready_in;
   logic          busy_out;
`ifdef FETCH_STATS_EN
   logic [15:0]   fetch_count_out;
   logic [15:0]   flush_count_out;
`endif

   always #5 clk_in = ~clk_in;

   instruction_fetch #(
      .INSTRUCTION_WIDTH (IW),
      .INSTRUCTION_COUNT (IC),
      .FIFO_DEPTH        (FD)
   ) dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .start_in         (start_in),
      .halt_in          (halt_in),
      .redirect_in      (redirect_in),
      .redirect_addr_in (redirect_addr_in),
      .bram_addr_out    (bram_addr_out),
      .bram_en_out      (bram_en_out),
      .bram_data_in     (bram_data_in),
      .instr_out        (instr_out),
      .instr_pc_out     (instr_pc_out),
      .instr_valid_out  (instr_valid_out),
      .instr_ready_in   (instr_ready_in),
      .busy_out         (busy_out)
`ifdef FETCH_STATS_EN
      ,
      .fetch_count_out  (fetch_count_out),
      .flush_count_out  (flush_count_out)
`endif
   );

   function automatic logic [IW-1:0] word_of(input logic [AW-1:0] a);
      return 32'hC0DE_0000 | {29'd0, a};
   endfunction

   // Program RAM: data for a strobe appears two cycles later; poison otherwise.
   logic          p1_v = 1'b0, p2_v = 1'b0;
   logic [AW-1:0] p1_a = '0, p2_a = '0;
   always @(posedge clk_in) begin
      p1_v <= bram_en_out;
      p1_a <= bram_addr_out;
      p2_v <= p1_v;
      p2_a <= p1_a;
   end
   assign bram_data_in = p2_v ? word_of(p2_a) : 32'hBAD0_BAD0;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   logic [AW+IW-1:0] exp_q[$];
   int               deliv_cyc[$];
   logic [AW-1:0]    strobe_log[$];
   logic [AW-1:0]    last_pc = '0;
   logic [AW+IW-1:0] mon_entry;

   always @(posedge clk_in) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: logs strobes and scores every accepted head against the queue.
   always @(negedge clk_in) begin
      if (bram_en_out) strobe_log.push_back(bram_addr_out);
      if (instr_valid_out && instr_ready_in) begin
         deliv_cyc.push_back(cyc);
         last_pc = instr_pc_out;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_delivery: got pc %0d, required no delivery", instr_pc_out);
         end else begin
            mon_entry = exp_q.pop_front();
            check("deliver", {instr_pc_out, instr_out}, mon_entry);
         end
      end
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic pulse_start();
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
   endtask

   task automatic expect_range(input int lo, input int hi);
      for (int a = lo; a <= hi; a++) exp_q.push_back({AW'(a), word_of(AW'(a))});
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_valid"}, instr_valid_out, 0);
      check({tag, "_en"}, bram_en_out, 0);
      check({tag, "_addr"}, bram_addr_out, 0);
      check({tag, "_instr"}, instr_out, 0);
      check({tag, "_pc"}, instr_pc_out, 0);
      check({tag, "_busy"}, busy_out, 0);
   endtask

   task automatic do_halt(input string tag);
      halt_in = 1'b1;
      tick();
      halt_in = 1'b0;
      check({tag, "_halt_busy"}, busy_out, 0);
      check({tag, "_halt_valid"}, instr_valid_out, 0);
   endtask

   initial begin
      int t0;
      int rel;
      rst_in = 1'b1; start_in = 1'b0; halt_in = 1'b0; redirect_in = 1'b0;
      redirect_addr_in = '0; instr_ready_in = 1'b0;
      repeat (3) @(posedge clk_in);
      #1;
      check_zero_outputs("rst");
`ifdef FETCH_STATS_EN
      check("rst_fetch_count", fetch_count_out, 0);
      check("rst_flush_count", flush_count_out, 0);
`endif
      rst_in = 1'b0;
      tick();

      // A: streaming with ready held high, run to the end of the program.
      instr_ready_in = 1'b1;
      strobe_log.delete(); deliv_cyc.delete();
      expect_range(0, 7);
      t0 = cyc;
      pulse_start();
      wait_drain("A_drain", 40);
      // start is sampled at cycle t0+1; the first head is visible three edges later
      check("A_latency", (deliv_cyc.size() > 0) ? deliv_cyc[0] - t0 : -1, 4);
      check("A_count", deliv_cyc.size(), 8);
      check("A_stream", (deliv_cyc.size() == 8) ? deliv_cyc[7] - deliv_cyc[0] : -1, 7);
      repeat (5) tick();
      check("A_last_pc", last_pc, 7);
      check("A_done_busy", busy_out, 1);
      check("A_reads", strobe_log.size(), 8);
      for (int i = 0; i < strobe_log.size(); i++) check("A_read_addr", strobe_log[i], i);
      pulse_start();
      repeat (6) tick();
      check("A_start_busy_ignored", strobe_log.size(), 8);
      do_halt("A");

      // B: controller stalls for 10 cycles after start.
      instr_ready_in = 1'b0;
      strobe_log.delete(); deliv_cyc.delete();
      pulse_start();
      repeat (10) begin
         @(negedge clk_in);
         if (instr_valid_out) begin
            check("B_hold_instr", instr_out, word_of(3'd0));
            check("B_hold_pc", instr_pc_out, 0);
         end
      end
      check("B_reads", strobe_log.size(), 4);
      check("B_valid", instr_valid_out, 1);
      expect_range(0, 7);
      tick();
      rel = cyc;
      instr_ready_in = 1'b1;
      wait_drain("B_drain", 40);
      check("B_first", (deliv_cyc.size() > 0) ? deliv_cyc[0] : -1, rel);
      check("B_burst", (deliv_cyc.size() >= 5) ? deliv_cyc[4] - deliv_cyc[0] : -1, 4);
      do_halt("B");

      // C: redirect to 7 with 2 queued and 2 in flight; head 0 accepted that cycle.
      instr_ready_in = 1'b0;
      strobe_log.delete(); deliv_cyc.delete();
      pulse_start();
      repeat (4) tick();
      expect_range(0, 0);
      expect_range(7, 7);
      redirect_in = 1'b1;
      redirect_addr_in = 3'd7;
      instr_ready_in = 1'b1;
      tick();
      redirect_in = 1'b0;
      strobe_log.delete();
      @(negedge clk_in);
      check("C_valid_low", instr_valid_out, 0);
      wait_drain("C_drain", 40);
      repeat (4) tick();
      check("C_last_pc", last_pc, 7);
      check("C_deliveries", deliv_cyc.size(), 2);
      check("C_reads", strobe_log.size(), 1);
      check("C_read_addr", (strobe_log.size() > 0) ? strobe_log[0] : 3'd0, 7);
      // halt and redirect together: halt wins
      halt_in = 1'b1;
      redirect_in = 1'b1;
      redirect_addr_in = 3'd3;
      tick();
      halt_in = 1'b0;
      redirect_in = 1'b0;
      check("C_prio_busy", busy_out, 0);
      strobe_log.delete();
      repeat (4) tick();
      check("C_prio_reads", strobe_log.size(), 0);

      // D: asynchronous reset with two reads in flight.
      instr_ready_in = 1'b1;
      pulse_start();
      repeat (2) tick();
      @(negedge clk_in);
      #2 rst_in = 1'b1;
      #1 check_zero_outputs("D_rst");
      tick();
      rst_in = 1'b0;
      repeat (10) tick();
      check("D_idle_busy", busy_out, 0);
      check("D_idle_valid", instr_valid_out, 0);

      // E: halt with 3 queued and 1 in flight.
      instr_ready_in = 1'b0;
      strobe_log.delete(); deliv_cyc.delete();
      pulse_start();
      repeat (5) tick();
      check("E_valid", instr_valid_out, 1);
`ifdef FETCH_STATS_EN
      check("E_flush_before", flush_count_out, 0);
`endif
      do_halt("E");
      check("E_reads", strobe_log.size(), 4);
`ifdef FETCH_STATS_EN
      check("E_flush_count", flush_count_out, 4);
      check("E_fetch_count", fetch_count_out, strobe_log.size());
`endif
      check("E_no_delivery", deliv_cyc.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of run, required completion");
      $fatal(1);
   end

endmodule
